neuron_mac: RTL and testbench

// - Sequential multiply-accumulate neuron front end: x·w dot product over N_INPUTS pairs plus bias.
// - Produces the saturated Q8.24 pre-activation that feeds the sigmoid activation stage directly downstream.
// - One pair is accepted per cycle via a valid/ready handshake.
// - The result is presented as a one-cycle out_valid pulse with y held until the next result.

---
 rtl/neuron_mac_pkg.sv | 17 +
 rtl/neuron_mac_reg.sv | 15 +
 rtl/neuron_mac.sv | 108 ++++++++++
 tb/tb_neuron_mac.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/neuron_mac_pkg.sv
// Fixed-point constants and FSM encodings shared by the neuron MAC and the
// activation stages that consume its Q8.24 output.
package neuron_mac_pkg;
    localparam int WIDTH_D = 32;
    localparam int FL_D    = 24;

    localparam logic [31:0] Q_ONE = 32'h0100_0000;
    localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_BIAS  = 2'd3
    } state_e;
endpackage

// File: rtl/neuron_mac_reg.sv
// Plain enabled pipeline register with synchronous active-high clear.
module neuron_mac_reg #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge clk_i) begin
        if (rst_i)     q_o <= '0;
        else if (en_i) q_o <= d_i;
    end
endmodule

// File: rtl/neuron_mac.sv
// Sequential x.w dot product plus bias, saturated to Q8.24, one pair per cycle.
module neuron_mac
    import neuron_mac_pkg::*;
#(
    parameter int WIDTH    = WIDTH_D,
    parameter int FL       = FL_D,
    parameter int N_INPUTS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] w_in,
    input  logic [WIDTH-1:0] bias,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] y
);
    localparam int GUARD = $clog2(N_INPUTS) + 1;
    localparam int PW    = 2*WIDTH - FL;
    localparam int ACC_W = PW + GUARD;
    localparam int CNT_W = $clog2(N_INPUTS) + 1;

    state_e             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [ACC_W-1:0]   acc_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   res_q;

    logic signed [2*WIDTH-1:0] prod_full;
    logic [PW-1:0]      prod_d, prod_q;
    logic               prod_v_q, accept, start_ok;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W-WIDTH:0] sum_hi;
    logic [WIDTH-1:0]   res_sat, y_d;
    logic               unused_prod_lsbs;

    assign in_ready = en && (state_q == S_ACCUM);
    assign accept   = in_valid && in_ready;
    // Busy covers the out_valid cycle, yet a start there must still be honoured.
    assign start_ok = start && (state_q == S_IDLE) && (!busy_q || out_valid);
    assign busy     = busy_q;

    assign prod_full = $signed({{WIDTH{x_in[WIDTH-1]}}, x_in})
                     * $signed({{WIDTH{w_in[WIDTH-1]}}, w_in});
    assign prod_d           = prod_full[2*WIDTH-1:FL];
    assign unused_prod_lsbs = ^prod_full[FL-1:0];

    always_comb begin
        sum    = acc_q + {{(ACC_W-WIDTH){bias[WIDTH-1]}}, bias};
        sum_hi = sum[ACC_W-1:WIDTH-1];
        if (&sum_hi || !(|sum_hi)) res_sat = sum[WIDTH-1:0];
        else if (sum[ACC_W-1])     res_sat = {1'b1, {(WIDTH-1){1'b0}}};
        else                       res_sat = {1'b0, {(WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else if (en) begin
            done_q <= 1'b0;
            if (prod_v_q) acc_q  <= acc_q + {{GUARD{prod_q[PW-1]}}, prod_q};
            if (out_valid) busy_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start_ok) begin
                    acc_q   <= '0;
                    count_q <= '0;
                    busy_q  <= 1'b1;
                    state_q <= S_ACCUM;
                end
                S_ACCUM: if (accept) begin
                    count_q <= count_q + CNT_W'(1);
                    if (count_q == CNT_W'(N_INPUTS-1)) state_q <= S_DRAIN;
                end
                S_DRAIN: state_q <= S_BIAS;
                S_BIAS: begin
                    res_q   <= res_sat;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign y_d = done_q ? res_q : y;

    neuron_mac_reg #(.W(PW)) u_prod (
        .clk_i(clk), .rst_i(rst), .en_i(en), .d_i(prod_d), .q_o(prod_q)
    );
    neuron_mac_reg #(.W(1)) u_prod_v (
        .clk_i(clk), .rst_i(rst), .en_i(en), .d_i(accept), .q_o(prod_v_q)
    );
    neuron_mac_reg #(.W(WIDTH)) u_y (
        .clk_i(clk), .rst_i(rst), .en_i(en), .d_i(y_d), .q_o(y)
    );
    neuron_mac_reg #(.W(1)) u_out_valid (
        .clk_i(clk), .rst_i(rst), .en_i(en), .d_i(done_q), .q_o(out_valid)
    );
endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with a transaction-level reference model.
module tb_neuron_mac;
    logic        clk = 1'b0;
    logic        rst, en, start, in_valid;
    logic [31:0] x_in, w_in, bias;
    logic        in_ready, busy, out_valid;
    logic [31:0] y;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    neuron_mac #(.WIDTH(32), .FL(24), .N_INPUTS(4)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .x_in(x_in), .w_in(w_in), .bias(bias),
        .busy(busy), .out_valid(out_valid), .y(y)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: tracks the transaction (collected pairs, edges since the
    // last pair) rather than any internal encoding.
    bit          m_col, m_busy, m_ov;
    int          m_n, m_cd;
    longint      m_sum;
    logic [31:0] m_y, m_fin;

    function automatic logic [31:0] satq(input longint s);
        longint v;
        v = s;
        if (v > 64'sd2147483647)       return 32'h7FFF_FFFF;
        else if (v < -64'sd2147483648) return 32'h8000_0000;
        else                           return v[31:0];
    endfunction

    always @(posedge clk) begin
        bit ov_prev, idle_ok, acc_ok;
        longint p;
        if (rst) begin
            m_col = 0; m_busy = 0; m_ov = 0; m_n = 0; m_cd = 0;
            m_sum = 0; m_y = 0; m_fin = 0;
        end else if (en) begin
            ov_prev = m_ov;
            idle_ok = !m_col && (m_cd == 0) && (!m_busy || ov_prev);
            acc_ok  = m_col && in_valid;
            m_ov = 0;
            if (ov_prev) m_busy = 0;
            if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 1) m_fin = satq(m_sum + longint'($signed(bias)));
                if (m_cd == 0) begin m_y = m_fin; m_ov = 1; end
            end
            if (acc_ok) begin
                p = longint'($signed(x_in)) * longint'($signed(w_in));
                m_sum += (p >>> 24);
                m_n++;
                if (m_n == 4) begin m_col = 0; m_cd = 3; end
            end
            if (idle_ok && start) begin
                m_col = 1; m_n = 0; m_sum = 0; m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("y", y, m_y);
            chk("busy", 32'(busy), 32'(m_busy));
            chk("in_ready", 32'(in_ready), 32'(en && m_col));
        end
    end

    task automatic cyc();
        @(posedge clk); #2;
    endtask

    task automatic feed(input logic [31:0] x, input logic [31:0] w);
        x_in = x; w_in = w; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_ov(input string nm);
        int k = 0;
        do begin @(negedge clk); k++; end while (!out_valid && k < 40);
        chk({nm, "_ov_seen"}, 32'(out_valid), 32'd1);
    endtask

    task automatic run(input string nm, input bit do_start, input logic [31:0] x[4],
                       input logic [31:0] w[4], input logic [31:0] b, input logic [31:0] ey);
        bias = b;
        if (do_start) begin start = 1'b1; cyc(); start = 1'b0; end
        for (int i = 0; i < 4; i++) feed(x[i], w[i]);
        cyc(); cyc();
        @(negedge clk) chk({nm, "_ov_early"}, 32'(out_valid), 32'd0);
        cyc();
        @(negedge clk);
        chk({nm, "_ov_lat3"}, 32'(out_valid), 32'd1);
        chk({nm, "_y"}, y, ey);
        chk({nm, "_model_y"}, m_y, ey);
        cyc();
        @(negedge clk) chk({nm, "_ov_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] xa[4], wa[4];
        bit vp[7];
        int xi;
        rst = 1'b1; en = 1'b1; start = 1'b0; in_valid = 1'b0;
        x_in = '0; w_in = '0; bias = '0;
        repeat (3) cyc();
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_y", y, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        cyc();

        xa = '{32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000};
        wa = '{32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000};
        run("basic", 1, xa, wa, 32'h0040_0000, 32'h0240_0000);

        xa = '{32'h6400_0000, 32'h6400_0000, 32'h6400_0000, 32'h6400_0000};
        wa = '{32'h6400_0000, 32'h6400_0000, 32'h6400_0000, 32'h6400_0000};
        run("sat_pos", 1, xa, wa, 32'h0, 32'h7FFF_FFFF);
        wa = '{32'h9C00_0000, 32'h9C00_0000, 32'h9C00_0000, 32'h9C00_0000};
        run("sat_neg", 1, xa, wa, 32'h0, 32'h8000_0000);

        xa = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        wa = '{32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000};
        run("floor", 1, xa, wa, 32'h0, 32'hFFFF_FFFC);

        // Gapped stream, mixed signs, then extra pairs that must be dropped.
        xa = '{32'h0100_0000, 32'hFE00_0000, 32'h0300_0000, 32'hFC00_0000};
        vp = '{1, 0, 0, 1, 1, 0, 1};
        bias = 32'h0; xi = 0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (vp[i]) begin feed(xa[xi], 32'h0100_0000); xi++; end
            else cyc();
        end
        x_in = 32'h0500_0000; in_valid = 1'b1;
        repeat (3) cyc();
        in_valid = 1'b0;
        wait_ov("gaps");
        chk("gaps_y", y, 32'hFE00_0000);
        cyc();

        // Freeze mid-ACCUM and during the out_valid pulse.
        bias = 32'h0100_0000;
        start = 1'b1; cyc(); start = 1'b0;
        feed(32'h0200_0000, 32'h0180_0000);
        feed(32'h0200_0000, 32'h0180_0000);
        en = 1'b0; in_valid = 1'b1; x_in = 32'h7F00_0000; w_in = 32'h7F00_0000;
        repeat (5) cyc();
        @(negedge clk) chk("frz_in_ready", 32'(in_ready), 32'd0);
        en = 1'b1;
        feed(32'h0200_0000, 32'h0180_0000);
        feed(32'h0200_0000, 32'h0180_0000);
        wait_ov("frz");
        en = 1'b0;
        repeat (5) cyc();
        @(negedge clk);
        chk("frz_ov_held", 32'(out_valid), 32'd1);
        chk("frz_y", y, 32'h0D00_0000);
        en = 1'b1;
        cyc();
        @(negedge clk) chk("frz_ov_clr", 32'(out_valid), 32'd0);

        // Abort by reset after two accepts.
        bias = 32'h0040_0000;
        start = 1'b1; cyc(); start = 1'b0;
        feed(32'h0100_0000, 32'h0080_0000);
        feed(32'h0100_0000, 32'h0080_0000);
        rst = 1'b1; cyc(); rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_y", y, 32'h0);
        repeat (6) cyc();
        @(negedge clk) chk("abort_no_ov", 32'(out_valid), 32'd0);
        xa = '{32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000};
        wa = '{32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000};
        run("fresh", 1, xa, wa, 32'h0040_0000, 32'h0240_0000);

        // Start held high: ignored while busy, taken in the out_valid cycle.
        bias = 32'h0;
        start = 1'b1; cyc();
        for (int i = 0; i < 4; i++) feed(32'h0040_0000, 32'h0100_0000);
        wait_ov("hold");
        chk("hold_y", y, 32'h0100_0000);
        cyc();
        start = 1'b0;
        @(negedge clk) chk("hold_busy_kept", 32'(busy), 32'd1);
        xa = '{32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000};
        run("b2b", 0, xa, wa, 32'h0, 32'hFE00_0000);

        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
